systolic_result_collector: RTL

- Output-side partner of continuous_systolic: drains the skewed result lanes `c` and turns them into aligned, whole result rows.
- Lane i of each row arrives i cycles after lane 0. The collector de-skews the lanes, frames exactly `size` rows per matrix, and buffers them in a small FIFO.
- Rows are handed downstream (backprop stack / writeback) over a valid/ready handshake.
- Data format is unchanged: Q(data_size/2).(data_size/2) two's-complement fixed point.

---
 rtl/systolic_result_collector.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/systolic_result_collector.sv
// De-skews the staggered result lanes of the systolic array, frames `size` rows per matrix and queues them for downstream.
// Optional build macro COLLECTOR_RELU_EN clamps negative elements to zero as rows enter the FIFO.
module systolic_result_collector #(
  parameter int data_size   = 16,
  parameter int size        = 3,
  parameter int lead_cycles = 3,
  parameter int fifo_depth  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [data_size*size-1:0] c_in,
  output logic [data_size*size-1:0] row_data,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      row_last,
  output logic                      matrix_done,
  output logic                      overflow
);

  localparam int width   = data_size * size;
  localparam int latency = lead_cycles + size - 1;
  localparam int wait_w  = $clog2(latency + 2);
  localparam int row_w   = $clog2(size + 1);
  localparam int aw      = $clog2(fifo_depth);
  localparam int cw      = aw + 1;

  // The start cycle itself counts, so the counter is loaded one short of the latency.
  localparam logic [wait_w-1:0] wait_load  = wait_w'(latency - 1);
  localparam logic [row_w-1:0]  last_row   = row_w'(size - 1);
  localparam logic [cw-1:0]     full_count = cw'(fifo_depth);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DONE} state_t;
  localparam state_t start_state = (latency <= 1) ? CAPTURE : WAIT;

  state_t             state, state_n;
  logic [wait_w-1:0]  wait_cnt, wait_n;
  logic [row_w-1:0]   row_cnt, row_n;
  logic               push, push_last;

  logic [data_size-1:0] aligned [size];
  logic [width-1:0]     push_row;

  logic [width-1:0]      mem_data [fifo_depth];
  logic [fifo_depth-1:0] mem_last;
  logic [width-1:0]      hold_data;
  logic [aw-1:0]         wr_ptr, rd_ptr;
  logic [cw-1:0]         count;
  logic                  empty, full, do_push, do_pop;

  function automatic logic [data_size-1:0] clamp(input logic [data_size-1:0] v);
`ifdef COLLECTOR_RELU_EN
    return v[data_size-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Lane i is delayed size-1-i cycles so every lane of a row lines up with the undelayed last lane.
  for (genvar i = 0; i < size; i++) begin : g_lane
    logic [data_size-1:0] lane_in;
    assign lane_in = c_in[data_size*(size-i)-1 -: data_size];
    if (i == size - 1) begin : g_direct
      assign aligned[i] = lane_in;
    end else begin : g_delay
      localparam int depth = size - 1 - i;
      logic [data_size-1:0] pipe [depth];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int j = 0; j < depth; j++) pipe[j] <= '0;
        end else begin
          pipe[0] <= lane_in;
          for (int j = 1; j < depth; j++) pipe[j] <= pipe[j-1];
        end
      end
      assign aligned[i] = pipe[depth-1];
    end
  end

  always_comb begin
    push_row = '0;
    for (int i = 0; i < size; i++) push_row[data_size*(size-i)-1 -: data_size] = clamp(aligned[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      row_cnt  <= row_n;
    end
  end

  // A start in any state restarts framing; rows already queued are left alone.
  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    row_n     = row_cnt;
    push      = 1'b0;
    push_last = 1'b0;
    case (state)
      IDLE: ;
      WAIT: begin
        if (wait_cnt == wait_w'(1)) begin
          state_n = CAPTURE;
          row_n   = '0;
        end else begin
          wait_n = wait_cnt - wait_w'(1);
        end
      end
      CAPTURE: begin
        push      = 1'b1;
        push_last = (row_cnt == last_row);
        if (row_cnt == last_row) state_n = DONE;
        else row_n = row_cnt + row_w'(1);
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (start) begin
      state_n   = start_state;
      wait_n    = wait_load;
      row_n     = '0;
      push      = 1'b0;
      push_last = 1'b0;
    end
  end

  assign matrix_done = (state == DONE);

  assign empty     = (count == '0);
  assign full      = (count == full_count);
  assign row_valid = !empty;
  assign do_pop    = row_valid && row_ready;
  assign do_push   = push && (!full || do_pop);
  assign row_data  = empty ? hold_data : mem_data[rd_ptr];
  assign row_last  = !empty && mem_last[rd_ptr];

  // hold_data keeps the last popped row visible once the FIFO runs dry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < fifo_depth; j++) mem_data[j] <= '0;
      mem_last  <= '0;
      hold_data <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) begin
        mem_data[wr_ptr] <= push_row;
        mem_last[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + aw'(1);
      end
      if (do_pop) begin
        hold_data <= mem_data[rd_ptr];
        rd_ptr    <= rd_ptr + aw'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: ;
      endcase
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule
